// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Phase sequencer for a single main/side intersection with a pedestrian
// crossing. A free-running prescaler produces one tick every TICK_DIV clocks.
// An 8-bit tick counter measures how long the current phase has lasted.
// Both counters restart whenever a new phase is entered. A phase of N ticks
// therefore lasts exactly N*TICK_DIV clocks.
//
// A rising edge on the debounced, level-held pedestrian button latches a walk
// request. The request is served by a WALK phase that is inserted between the
// main-road clearance and the side-road green.
//
// Optional feature (compile-time macro TLC_WALK_FLASH_EN):
//   defined   - during the last FLASH_TICKS ticks of WALK the walk light
//               blinks once per tick. It is on for the first TICK_DIV/2 clocks
//               of each tick and off for the rest.
//   undefined - the walk light is solid for the whole WALK phase and
//               FLASH_TICKS has no effect.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   walk_req   in   debounced pedestrian button, level (high while held)
//   sensor     in   side-street car present, level
//   main_light out  {R,Y,G} one-hot, main road
//   side_light out  {R,Y,G} one-hot, side road
//   walk_light out  walk signal
//   walk_ack   out  one-cycle pulse when a new walk request is latched
//   state_o    out  current state encoding (debug)
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter logic [15:0] TICK_DIV     = 16'd50000,
  parameter logic [7:0]  GREEN_TICKS  = 8'd10,
  parameter logic [7:0]  YELLOW_TICKS = 8'd3,
  parameter logic [7:0]  ALLRED_TICKS = 8'd1,
  parameter logic [7:0]  SIDE_TICKS   = 8'd6,
  parameter logic [7:0]  WALK_TICKS   = 8'd5,
  parameter logic [7:0]  FLASH_TICKS  = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       walk_req,
  input  logic       sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic       walk_ack,
  output logic [2:0] state_o
);

  // Light codes, {R,Y,G}.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    WALK        = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [15:0] presc_q;
  logic [15:0] presc_d;
  logic [7:0]  tick_cnt_q;
  logic [7:0]  tick_cnt_d;
  logic        walk_req_q;
  logic        walk_pending_q;
  logic        walk_pending_d;
  logic        walk_ack_d;
  logic [2:0]  main_light_d;
  logic [2:0]  side_light_d;
  logic        walk_light_d;

  // ---------------------------------------------------------------------------
  // Timing helpers
  // ---------------------------------------------------------------------------
  logic tick;
  logic green_done;
  logic state_change;
  logic entering_walk;
  logic walk_edge;

  assign tick = (presc_q == TICK_DIV - 16'd1);

  // The main-green counter saturates at GREEN_TICKS. Once it gets there the
  // minimum green has elapsed and the phase may end on any cycle, not only on
  // a tick. This makes a car or a request that arrives late get served at once.
  assign green_done = (tick_cnt_q == GREEN_TICKS) ||
                      (tick && (tick_cnt_q == GREEN_TICKS - 8'd1));

  assign walk_edge = walk_req && !walk_req_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb block gets a default value on
  // its first line. Otherwise a path that does not assign it infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MAIN_GREEN: begin
        if (green_done && (sensor || walk_pending_q)) state_d = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        if (tick && (tick_cnt_q == YELLOW_TICKS - 8'd1)) state_d = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (tick && (tick_cnt_q == ALLRED_TICKS - 8'd1))
          state_d = walk_pending_q ? WALK : SIDE_GREEN;
      end
      WALK: begin
        if (tick && (tick_cnt_q == WALK_TICKS - 8'd1))
          state_d = sensor ? SIDE_GREEN : ALL_RED_B;
      end
      SIDE_GREEN: begin
        if (tick && (tick_cnt_q == SIDE_TICKS - 8'd1)) state_d = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        if (tick && (tick_cnt_q == YELLOW_TICKS - 8'd1)) state_d = ALL_RED_B;
      end
      ALL_RED_B: begin
        if (tick && (tick_cnt_q == ALLRED_TICKS - 8'd1)) state_d = MAIN_GREEN;
      end
      // The unused encoding 7 goes to a safe all-red clearance state.
      default: state_d = ALL_RED_B;
    endcase
  end

  assign state_change  = (state_d != state_q);
  assign entering_walk = (state_d == WALK) && (state_q != WALK);

  // ---------------------------------------------------------------------------
  // Prescaler and tick counter; both restart on phase entry
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d    = presc_q + 16'd1;
    tick_cnt_d = tick_cnt_q;
    if (state_change) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      presc_d = '0;
      // Only main green can stay past its terminal tick. Its counter holds at
      // GREEN_TICKS so it does not wrap back into the minimum-green window.
      if (!((state_q == MAIN_GREEN) && (tick_cnt_q == GREEN_TICKS)))
        tick_cnt_d = tick_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Walk request latch
  // ---------------------------------------------------------------------------
  // Clearing on entry to WALK takes priority over a simultaneous edge, so that
  // edge is dropped without an ack. Edges during WALK are ignored.
  always_comb begin
    walk_pending_d = walk_pending_q;
    walk_ack_d     = 1'b0;
    if (entering_walk) begin
      walk_pending_d = 1'b0;
    end else if (walk_edge && (state_q != WALK)) begin
      walk_pending_d = 1'b1;
      walk_ack_d     = !walk_pending_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Light decode from the next state
  // ---------------------------------------------------------------------------
  // The decode uses the next state, so the registered lights change in the
  // same cycle as state_o. Any encoding outside the table shows all red.
  always_comb begin
    main_light_d = LIGHT_RED;
    side_light_d = LIGHT_RED;
    walk_light_d = 1'b0;
    case (state_d)
      MAIN_GREEN:  main_light_d = LIGHT_GREEN;
      MAIN_YELLOW: main_light_d = LIGHT_YELLOW;
      SIDE_GREEN:  side_light_d = LIGHT_GREEN;
      SIDE_YELLOW: side_light_d = LIGHT_YELLOW;
      WALK: begin
`ifdef TLC_WALK_FLASH_EN
        // The counter values used here are the ones the registered light
        // will be displayed with. Inside the flash window the light is on for
        // the first half of each tick.
        if (tick_cnt_d >= (WALK_TICKS - FLASH_TICKS))
          walk_light_d = (presc_d < (TICK_DIV >> 1));
        else
          walk_light_d = 1'b1;
`else
        walk_light_d = 1'b1;
`endif
      end
      default: begin
        main_light_d = LIGHT_RED;
        side_light_d = LIGHT_RED;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples the values from before this edge, whatever order
  // the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= MAIN_GREEN;
      presc_q        <= '0;
      tick_cnt_q     <= '0;
      walk_req_q     <= 1'b0;
      walk_pending_q <= 1'b0;
      walk_ack       <= 1'b0;
      main_light     <= LIGHT_GREEN;
      side_light     <= LIGHT_RED;
      walk_light     <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      tick_cnt_q     <= tick_cnt_d;
      walk_req_q     <= walk_req;
      walk_pending_q <= walk_pending_d;
      walk_ack       <= walk_ack_d;
      main_light     <= main_light_d;
      side_light     <= side_light_d;
      walk_light     <= walk_light_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Scenario bench for traffic_light_ctrl with short phase timings.
// Each scenario pushes the state transitions and walk_ack pulses it expects.
// A per-cycle monitor pops those entries when the DUT produces them and
// compares cycle numbers, states and lights. Cycle 0 is the clock period in
// which reset is released.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

  localparam logic [15:0] TD = 16'd4;
  localparam logic [7:0]  GT = 8'd3;
  localparam logic [7:0]  YT = 8'd2;
  localparam logic [7:0]  AT = 8'd1;
  localparam logic [7:0]  ST = 8'd3;
  localparam logic [7:0]  WT = 8'd4;
  localparam logic [7:0]  FT = 8'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       walk_req;
  logic       sensor;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic       walk_ack;
  logic [2:0] state_o;

  traffic_light_ctrl #(
    .TICK_DIV    (TD),
    .GREEN_TICKS (GT),
    .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT),
    .SIDE_TICKS  (ST),
    .WALK_TICKS  (WT),
    .FLASH_TICKS (FT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .walk_req  (walk_req),
    .sensor    (sensor),
    .main_light(main_light),
    .side_light(side_light),
    .walk_light(walk_light),
    .walk_ack  (walk_ack),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [2:0] ml;
    logic [2:0] sl;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];

  int         checks = 0;
  int         passed = 0;
  int         cyc;
  int         walk_entry = 0;
  logic [2:0] last_st;
  logic [2:0] cur_ml;
  logic [2:0] cur_sl;

  // Light table, written out independently from the state list.
  function automatic exp_t mk(input int c, input logic [2:0] s);
    exp_t e;
    e.cyc = c;
    e.st  = s;
    e.ml  = 3'b100;
    e.sl  = 3'b100;
    case (s)
      3'd0: e.ml = 3'b001;
      3'd1: e.ml = 3'b010;
      3'd4: e.sl = 3'b001;
      3'd5: e.sl = 3'b010;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push_tr(input int c, input logic [2:0] s);
    exp_q.push_back(mk(c, s));
  endtask

  // Holds reset, checks the reset values, then releases reset just after a
  // rising edge. The rest of that clock period is cycle 0.
  task automatic test_reset();
    rst      = 1'b1;
    walk_req = 1'b0;
    sensor   = 1'b0;
    exp_q.delete();
    ack_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({state_o, main_light, side_light, walk_light, walk_ack} !==
        {3'd0, 3'b001, 3'b100, 1'b0, 1'b0})
      $display("FAIL reset_values: got st=%0d m=%b s=%b w=%b a=%b, want st=0 m=001 s=100 w=0 a=0",
               state_o, main_light, side_light, walk_light, walk_ack);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    last_st = 3'd0;
    cur_ml  = 3'b001;
    cur_sl  = 3'b100;
  endtask

  // Per-cycle comparison against the scoreboard. Called at the falling edge.
  task automatic monitor();
    logic wl_exp;
    int   idx;
    if (state_o !== last_st) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL transition: unexpected state %0d at cycle %0d", state_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cur_ml = e.ml;
        cur_sl = e.sl;
        if ((e.cyc != cyc) || (e.st !== state_o))
          $display("FAIL transition: got state %0d at cycle %0d, want state %0d at cycle %0d",
                   state_o, cyc, e.st, e.cyc);
        else passed++;
      end
      if (state_o == 3'd3) walk_entry = cyc;
      last_st = state_o;
    end

    wl_exp = 1'b0;
    if (state_o == 3'd3) begin
      idx = cyc - walk_entry;
`ifdef TLC_WALK_FLASH_EN
      if (idx < int'(WT - FT) * int'(TD)) wl_exp = 1'b1;
      else wl_exp = ((idx % int'(TD)) < (int'(TD) / 2));
`else
      wl_exp = 1'b1;
`endif
    end
    checks++;
    if ({main_light, side_light, walk_light} !== {cur_ml, cur_sl, wl_exp})
      $display("FAIL lights: cycle %0d got m=%b s=%b w=%b, want m=%b s=%b w=%b",
               cyc, main_light, side_light, walk_light, cur_ml, cur_sl, wl_exp);
    else passed++;

    checks++;
    if ((main_light[0] && side_light[0]) ||
        (walk_light && (main_light[0] || side_light[0])))
      $display("FAIL safety: cycle %0d conflicting greens m=%b s=%b w=%b",
               cyc, main_light, side_light, walk_light);
    else passed++;

    if (walk_ack === 1'b1) begin
      checks++;
      if (ack_q.size() == 0) begin
        $display("FAIL walk_ack: unexpected pulse at cycle %0d", cyc);
      end else begin
        int c;
        c = ack_q.pop_front();
        if (c != cyc) $display("FAIL walk_ack: pulse at cycle %0d, want cycle %0d", cyc, c);
        else passed++;
      end
    end
  endtask

  task automatic end_check(input string name);
    checks++;
    if ((exp_q.size() != 0) || (ack_q.size() != 0))
      $display("FAIL %s_drain: %0d transitions and %0d acks never seen, want 0 and 0",
               name, exp_q.size(), ack_q.size());
    else passed++;
  endtask

  task automatic test_idle();
    test_reset();
    for (int c = 0; c < 200; c++) begin
      cyc = c; sensor = 1'b0; walk_req = 1'b0;
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("idle");
  endtask

  task automatic test_sensor_cycle();
    test_reset();
    push_tr(12, 3'd1); push_tr(20, 3'd2); push_tr(24, 3'd4);
    push_tr(36, 3'd5); push_tr(44, 3'd6); push_tr(48, 3'd0);
    for (int c = 0; c < 58; c++) begin
      cyc = c; sensor = 1'b1; walk_req = 1'b0;
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("sensor");
  endtask

  task automatic test_late_sensor();
    test_reset();
    push_tr(31, 3'd1); push_tr(39, 3'd2); push_tr(43, 3'd4);
    for (int c = 0; c < 50; c++) begin
      cyc = c; sensor = (c >= 30); walk_req = 1'b0;
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("late_sensor");
  endtask

  task automatic push_walk_seq();
    ack_q.push_back(3);
    push_tr(12, 3'd1); push_tr(20, 3'd2); push_tr(24, 3'd3);
    push_tr(40, 3'd6); push_tr(44, 3'd0);
  endtask

  task automatic test_walk();
    test_reset();
    push_walk_seq();
    for (int c = 0; c < 80; c++) begin
      cyc = c; sensor = 1'b0; walk_req = (c >= 2) && (c <= 30);
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("walk");
  endtask

  task automatic test_back_to_back();
    test_reset();
    push_walk_seq();
    for (int c = 0; c < 90; c++) begin
      cyc = c; sensor = 1'b0;
      walk_req = (c inside {[2:3], [6:7], [28:29]});
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("back_to_back");
  endtask

  task automatic test_edge_at_walk_entry();
    test_reset();
    push_walk_seq();
    for (int c = 0; c < 80; c++) begin
      cyc = c; sensor = 1'b0;
      walk_req = ((c >= 2) && (c <= 5)) || (c >= 23);
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("walk_entry_edge");
  endtask

  task automatic test_walk_then_side();
    test_reset();
    ack_q.push_back(3);
    push_tr(12, 3'd1); push_tr(20, 3'd2); push_tr(24, 3'd3); push_tr(40, 3'd4);
    push_tr(52, 3'd5); push_tr(60, 3'd6); push_tr(64, 3'd0); push_tr(76, 3'd1);
    push_tr(84, 3'd2); push_tr(88, 3'd4);
    for (int c = 0; c < 95; c++) begin
      cyc = c; sensor = 1'b1; walk_req = (c >= 2) && (c <= 3);
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("walk_side");
  endtask

  task automatic test_async_reset();
    test_reset();
    push_tr(12, 3'd1); push_tr(20, 3'd2); push_tr(24, 3'd4);
    ack_q.push_back(27);
    for (int c = 0; c < 28; c++) begin
      cyc = c; sensor = 1'b1; walk_req = (c == 26);
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    // Mid SIDE_GREEN, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state_o, main_light, side_light, walk_light, walk_ack} !==
        {3'd0, 3'b001, 3'b100, 1'b0, 1'b0})
      $display("FAIL async_reset: got st=%0d m=%b s=%b w=%b a=%b, want st=0 m=001 s=100 w=0 a=0",
               state_o, main_light, side_light, walk_light, walk_ack);
    else passed++;
    end_check("async_pre");
    @(posedge clk);
    #1 rst = 1'b0;
    last_st = 3'd0;
    cur_ml  = 3'b001;
    cur_sl  = 3'b100;
    // The request latched before reset must be gone, so nothing moves.
    for (int c = 0; c < 60; c++) begin
      cyc = c; sensor = 1'b0; walk_req = 1'b0;
      @(negedge clk); monitor(); @(posedge clk); #1;
    end
    end_check("async_post");
  endtask

  initial begin
    test_idle();
    test_sensor_cycle();
    test_late_sensor();
    test_walk();
    test_back_to_back();
    test_edge_at_walk_entry();
    test_walk_then_side();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
